// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default operand width.
package serial_adder_pkg;

  localparam int ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2,
    ST_SPARE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half-adder stages; the single arithmetic cell of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s_half;
  logic c_half_ab;
  logic c_half_ci;

  assign s_half    = a ^ b;
  assign c_half_ab = a & b;
  assign s         = s_half ^ ci;
  assign c_half_ci = s_half & ci;
  assign co        = c_half_ab | c_half_ci;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder cell,
// with a ready/start/done handshake and registered sum/carry-out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             READY,
  output logic             BUSY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign READY    = (state == ST_IDLE);
  assign BUSY     = (state == ST_RUN) || (state == ST_FINISH);

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    sum_nx            = sum_sr >> 1;
    sum_nx[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (START) state_nx = ST_RUN;
      ST_RUN:    if (last_bit) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Result registers load on the last RUN edge so S/CO/DONE are all valid together in FINISH.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      CO     <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            carry  <= CI;
            sum_sr <= '0;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nx;
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            S    <= sum_nx;
            CO   <= fa_co;
            DONE <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=1, 8 and 32 against a plain-arithmetic golden model.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;

  logic        ready1, busy1, co1, done1;
  logic [0:0]  s1;
  logic        ready8, busy8, co8, done8;
  logic [7:0]  s8;
  logic        ready32, busy32, co32, done32;
  logic [31:0] s32;

  int errors = 0;
  int checks = 0;
  int done_cnt8 = 0;
  logic done1_prev = 1'b0, done8_prev = 1'b0, done32_prev = 1'b0;

  serial_adder #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start), .A(a[0:0]), .B(b[0:0]), .CI(ci),
    .READY(ready1), .BUSY(busy1), .S(s1), .CO(co1), .DONE(done1)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start), .A(a[7:0]), .B(b[7:0]), .CI(ci),
    .READY(ready8), .BUSY(busy8), .S(s8), .CO(co8), .DONE(done8)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b), .CI(ci),
    .READY(ready32), .BUSY(busy32), .S(s32), .CO(co32), .DONE(done32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden result {carry-out, sum} from the true (w+1)-bit sum.
  function automatic logic [32:0] golden(input logic [31:0] av, input logic [31:0] bv,
                                         input logic civ, input int w);
    longint unsigned mask, sum;
    mask = (64'd1 << w) - 64'd1;
    sum  = (longint'(av) & mask) + (longint'(bv) & mask) + longint'(civ);
    return {((sum >> w) & 64'd1) != 64'd0, 32'(sum & mask)};
  endfunction

  // Continuous protocol watch: READY/BUSY exclusive, DONE never longer than one cycle.
  always @(negedge clk) begin
    checks += 3;
    if (ready1 && busy1)   begin errors++; $display("[TB] FAIL excl_w1 ready=%0b busy=%0b required not both", ready1, busy1); end
    if (ready8 && busy8)   begin errors++; $display("[TB] FAIL excl_w8 ready=%0b busy=%0b required not both", ready8, busy8); end
    if (ready32 && busy32) begin errors++; $display("[TB] FAIL excl_w32 ready=%0b busy=%0b required not both", ready32, busy32); end
    if (done1)  begin checks++; if (done1_prev)  begin errors++; $display("[TB] FAIL done_width_w1 got 2+ cycles required 1"); end end
    if (done8)  begin checks++; done_cnt8++; if (done8_prev) begin errors++; $display("[TB] FAIL done_width_w8 got 2+ cycles required 1"); end end
    if (done32) begin checks++; if (done32_prev) begin errors++; $display("[TB] FAIL done_width_w32 got 2+ cycles required 1"); end end
    done1_prev  = done1;
    done8_prev  = done8;
    done32_prev = done32;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Launches one operation on an idle WIDTH=8 block and returns negedges from acceptance to DONE.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic civ, output int lat);
    @(negedge clk);
    a = {24'd0, av};
    b = {24'd0, bv};
    ci = civ;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (ready8 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b required 1", ready8); end
    if (busy8 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy got %0b required 0", busy8); end
    if (s8 !== 8'h00)    begin errors++; $display("[TB] FAIL reset_s got %0h required 00", s8); end
    if (co8 !== 1'b0)    begin errors++; $display("[TB] FAIL reset_co got %0b required 0", co8); end
    if (done8 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done got %0b required 0", done8); end
  endtask

  task automatic test_basic();
    int lat;
    logic [32:0] exp;
    exp = golden(32'h5A, 32'h3C, 1'b0, 8);
    do_op8(8'h5A, 8'h3C, 1'b0, lat);
    checks += 3;
    if (lat !== 9)            begin errors++; $display("[TB] FAIL basic_latency got %0d required 9", lat); end
    if (s8 !== exp[7:0])      begin errors++; $display("[TB] FAIL basic_s got %0h required %0h", s8, exp[7:0]); end
    if (co8 !== exp[32])      begin errors++; $display("[TB] FAIL basic_co got %0b required %0b", co8, exp[32]); end
    @(negedge clk);
    checks += 2;
    if (ready8 !== 1'b1)      begin errors++; $display("[TB] FAIL basic_ready_after got %0b required 1", ready8); end
    if (s8 !== exp[7:0])      begin errors++; $display("[TB] FAIL basic_s_hold got %0h required %0h", s8, exp[7:0]); end
  endtask

  task automatic test_carry_corners();
    logic [7:0] ta [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] tb [3] = '{8'h01, 8'hFF, 8'h00};
    logic       tc [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    logic [32:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = golden({24'd0, ta[i]}, {24'd0, tb[i]}, tc[i], 8);
      do_op8(ta[i], tb[i], tc[i], lat);
      @(negedge clk);
      checks += 2;
      if (s8 !== exp[7:0]) begin errors++; $display("[TB] FAIL corner%0d_s got %0h required %0h", i, s8, exp[7:0]); end
      if (co8 !== exp[32]) begin errors++; $display("[TB] FAIL corner%0d_co got %0b required %0b", i, co8, exp[32]); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, cnt_before;
    @(negedge clk);
    cnt_before = done_cnt8;
    a = 32'h12; b = 32'h34; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 32'hFF; b = 32'hFF; ci = 1'b1; start = 1'b1;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL busy_during_run got %0b required 1", busy8); end
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done8 && lat < 100) begin @(negedge clk); lat++; end
    checks += 3;
    if (lat !== 9)      begin errors++; $display("[TB] FAIL busy_latency got %0d required 9", lat); end
    if (s8 !== 8'h46)   begin errors++; $display("[TB] FAIL busy_s got %0h required 46", s8); end
    if (co8 !== 1'b0)   begin errors++; $display("[TB] FAIL busy_co got %0b required 0", co8); end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt8 - cnt_before !== 1) begin errors++; $display("[TB] FAIL busy_done_count got %0d required 1", done_cnt8 - cnt_before); end
  endtask

  task automatic test_mid_reset();
    int lat, cnt_before;
    @(negedge clk);
    cnt_before = done_cnt8;
    a = 32'h5A; b = 32'h3C; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy got %0b required 1", busy8); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 3;
    if (ready8 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %0b required 1", ready8); end
    if (s8 !== 8'h00)    begin errors++; $display("[TB] FAIL midrst_s got %0h required 00", s8); end
    if (co8 !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_co got %0b required 0", co8); end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt8 !== cnt_before) begin errors++; $display("[TB] FAIL midrst_no_done got %0d required %0d", done_cnt8, cnt_before); end
    do_op8(8'h01, 8'h01, 1'b0, lat);
    checks++;
    if (s8 !== 8'h02) begin errors++; $display("[TB] FAIL midrst_after_s got %0h required 02", s8); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic       oc [4];
    logic [32:0] exp;
    int gap;
    for (int i = 0; i < 4; i++) begin
      oa[i] = 8'($urandom); ob[i] = 8'($urandom); oc[i] = 1'($urandom);
    end
    repeat (2) @(negedge clk);
    a = {24'd0, oa[0]}; b = {24'd0, ob[0]}; ci = oc[0]; start = 1'b1;
    @(negedge clk);
    a = {24'd0, oa[1]}; b = {24'd0, ob[1]}; ci = oc[1];
    gap = 0;
    for (int k = 0; k < 3; k++) begin
      while (!done8 && gap < 100) begin @(negedge clk); gap++; end
      exp = golden({24'd0, oa[k]}, {24'd0, ob[k]}, oc[k], 8);
      checks += 2;
      if (s8 !== exp[7:0]) begin errors++; $display("[TB] FAIL b2b%0d_s got %0h required %0h", k, s8, exp[7:0]); end
      if (co8 !== exp[32]) begin errors++; $display("[TB] FAIL b2b%0d_co got %0b required %0b", k, co8, exp[32]); end
      if (k > 0) begin
        checks++;
        if (gap !== 10) begin errors++; $display("[TB] FAIL b2b%0d_interval got %0d required 10", k, gap); end
      end
      gap = 0;
      if (k == 2) start = 1'b0;
      else begin
        @(negedge clk);
        @(negedge clk);
        gap = 2;
        a = {24'd0, oa[k+2]}; b = {24'd0, ob[k+2]}; ci = oc[k+2];
      end
    end
  endtask

  task automatic test_random_sweep();
    logic [32:0] e1, e8, e32;
    bit seen1, seen8, seen32;
    int n;
    apply_reset();
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      checks++;
      if (!(ready1 && ready8 && ready32)) begin
        errors++;
        $display("[TB] FAIL sweep_ready it=%0d got %0b%0b%0b required 111", it, ready1, ready8, ready32);
      end
      a = $urandom; b = $urandom; ci = 1'($urandom);
      e1 = golden(a, b, ci, 1); e8 = golden(a, b, ci, 8); e32 = golden(a, b, ci, 32);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; ci = 1'($urandom);
      seen1 = 0; seen8 = 0; seen32 = 0; n = 0;
      while (!(seen1 && seen8 && seen32) && n < 60) begin
        if (done1 && !seen1) begin
          seen1 = 1; checks += 2;
          if (s1 !== e1[0:0])  begin errors++; $display("[TB] FAIL sweep_w1_s it=%0d got %0h required %0h", it, s1, e1[0:0]); end
          if (co1 !== e1[32])  begin errors++; $display("[TB] FAIL sweep_w1_co it=%0d got %0b required %0b", it, co1, e1[32]); end
        end
        if (done8 && !seen8) begin
          seen8 = 1; checks += 2;
          if (s8 !== e8[7:0])  begin errors++; $display("[TB] FAIL sweep_w8_s it=%0d got %0h required %0h", it, s8, e8[7:0]); end
          if (co8 !== e8[32])  begin errors++; $display("[TB] FAIL sweep_w8_co it=%0d got %0b required %0b", it, co8, e8[32]); end
        end
        if (done32 && !seen32) begin
          seen32 = 1; checks += 2;
          if (s32 !== e32[31:0]) begin errors++; $display("[TB] FAIL sweep_w32_s it=%0d got %0h required %0h", it, s32, e32[31:0]); end
          if (co32 !== e32[32])  begin errors++; $display("[TB] FAIL sweep_w32_co it=%0d got %0b required %0b", it, co32, e32[32]); end
        end
        @(negedge clk);
        n++;
      end
      checks++;
      if (!(seen1 && seen8 && seen32)) begin
        errors++;
        $display("[TB] FAIL sweep_timeout it=%0d got done %0b%0b%0b required 111", it, seen1, seen8, seen32);
        apply_reset();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    test_reset();
    test_basic();
    test_carry_corners();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
